// File: rtl/ws2811_frame_feeder_pkg.sv
// Shared definitions for the WS2811 byte feeder and serialiser: FSM encoding,
// byte width and the default latch-gap length derived from the system clock.
package ws2811_frame_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int BYTE_W             = 8;
    localparam int CLKIN_HZ           = 12_000_000;
    localparam int LATCH_GAP_US       = 80;
    localparam int DEFAULT_GAP_CYCLES = (CLKIN_HZ / 1_000_000) * LATCH_GAP_US;

    // A 1-cycle gap still needs a 1-bit counter.
    function automatic int gap_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ws2811_frame_feeder_pixel_bank.sv
// Two pixel-byte register banks: the host writes the back bank, the streamer
// reads whichever bank rd_sel names (lets a swap and a frame start share an edge).
module ws2811_frame_feeder_pixel_bank
    import ws2811_frame_feeder_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_front,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic              i_rd_sel,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    logic [BYTE_W-1:0] w_bank0 [NUM_BYTES];
    logic [BYTE_W-1:0] w_bank1 [NUM_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            logic [BYTE_W-1:0] r_b0;
            logic [BYTE_W-1:0] r_b1;
            // Addresses beyond NUM_BYTES-1 match no slot and are dropped here.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_b0 <= '0;
                    r_b1 <= '0;
                end else if (i_we && (i_waddr == ADDR_W'(gi))) begin
                    if (i_front) begin
                        r_b0 <= i_wdata;
                    end else begin
                        r_b1 <= i_wdata;
                    end
                end
            end
            assign w_bank0[gi] = r_b0;
            assign w_bank1[gi] = r_b1;
        end
    endgenerate

    assign o_rd_data = i_rd_sel ? w_bank1[i_rd_addr] : w_bank0[i_rd_addr];

endmodule

// File: rtl/ws2811_frame_feeder.sv
// Double-buffered frame source for the WS2811 serialiser: streams the front
// bank over VALID/READY, then holds BUSY through the LED latch gap.
module ws2811_frame_feeder
    import ws2811_frame_feeder_pkg::*;
#(
    parameter int NUM_BYTES  = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic              i_clkin,
    input  logic              i_resetn,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic              i_swap,
    input  logic              i_start,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_swapped
);

    localparam int                GAP_W    = gap_width(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_idx, w_idx_next;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_next;
    logic [BYTE_W-1:0] r_data, w_data_next;
    logic              r_valid, w_valid_next;
    logic              r_last, w_last_next;
    logic              r_busy, w_busy_next;
    logic              r_front, r_swap_pend, r_swapped;

    logic              w_xfer, w_final, w_swap_req, w_do_swap, w_rd_sel;
    logic [ADDR_W-1:0] w_idx_inc, w_rd_addr;
    logic [BYTE_W-1:0] w_rd_data;

    assign w_xfer     = (r_state == ST_STREAM) && r_valid && i_ready;
    assign w_final    = w_xfer && r_last;
    // A SWAP on the same edge as START or the final transfer counts as pending.
    assign w_swap_req = r_swap_pend | i_swap;
    assign w_do_swap  = w_swap_req && ((r_state == ST_IDLE) || w_final);
    assign w_rd_sel   = r_front ^ w_do_swap;
    assign w_idx_inc  = r_idx + 1'b1;
    assign w_rd_addr  = (r_state == ST_IDLE) ? '0 : w_idx_inc;

    ws2811_frame_feeder_pixel_bank #(
        .NUM_BYTES (NUM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .i_clk     (i_clkin),
        .i_rst_n   (i_resetn),
        .i_front   (r_front),
        .i_we      (i_we),
        .i_waddr   (i_waddr),
        .i_wdata   (i_wdata),
        .i_rd_sel  (w_rd_sel),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_gap_next   = r_gap_cnt;
        w_data_next  = r_data;
        w_valid_next = r_valid;
        w_last_next  = r_last;
        w_busy_next  = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_STREAM;
                    w_idx_next   = '0;
                    w_data_next  = w_rd_data;
                    w_valid_next = 1'b1;
                    w_last_next  = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end
            ST_STREAM: begin
                if (w_xfer) begin
                    if (r_last) begin
                        w_state_next = ST_GAP;
                        w_valid_next = 1'b0;
                        w_last_next  = 1'b0;
                        w_gap_next   = GAP_LOAD;
                    end else begin
                        w_idx_next   = w_idx_inc;
                        w_data_next  = w_rd_data;
                        w_last_next  = (w_idx_inc == LAST_IDX);
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                end else begin
                    w_gap_next   = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_valid_next = 1'b0;
                w_last_next  = 1'b0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clkin or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
            r_swapped   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_gap_cnt   <= w_gap_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_last      <= w_last_next;
            r_busy      <= w_busy_next;
            r_front     <= r_front ^ w_do_swap;
            r_swap_pend <= w_swap_req & ~w_do_swap;
            r_swapped   <= w_do_swap;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_last    = r_last;
    assign o_busy    = r_busy;
    assign o_swapped = r_swapped;

endmodule

// File: tb/tb_ws2811_frame_feeder.sv
// Randomised bench for ws2811_frame_feeder against a bank/queue model of the
// double-buffered frame source.
module tb_ws2811_frame_feeder;

    localparam int NB  = 16;
    localparam int GAP = 960;
    localparam int NB_B  = 12;
    localparam int GAP_B = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0, swap = 1'b0, start = 1'b0, ready = 1'b0;
    logic [3:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] data;
    logic       valid, last, busy, swapped;

    logic       b_we = 1'b0, b_swap = 1'b0, b_start = 1'b0, b_ready = 1'b0;
    logic [3:0] b_waddr = '0;
    logic [7:0] b_wdata = '0;
    logic [7:0] b_data;
    logic       b_valid, b_last, b_busy, b_swapped;

    int n_total = 0;
    int n_bad   = 0;

    // Model: two banks indexed by logical role, plus which one is in front.
    int m_bank [2][NB];
    int m_front = 0;
    bit m_pend  = 0;

    always #5 clk = ~clk;

    ws2811_frame_feeder #(.NUM_BYTES(NB), .ADDR_W(4), .GAP_CYCLES(GAP)) dut (
        .i_clkin(clk), .i_resetn(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_swap(swap), .i_start(start), .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_last(last), .o_busy(busy), .o_swapped(swapped)
    );

    ws2811_frame_feeder #(.NUM_BYTES(NB_B), .ADDR_W(4), .GAP_CYCLES(GAP_B)) dut_b (
        .i_clkin(clk), .i_resetn(rst_n), .i_we(b_we), .i_waddr(b_waddr), .i_wdata(b_wdata),
        .i_swap(b_swap), .i_start(b_start), .o_data(b_data), .o_valid(b_valid), .i_ready(b_ready),
        .o_last(b_last), .o_busy(b_busy), .o_swapped(b_swapped)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NB; i++) m_bank[b][i] = 0;
        m_front = 0;
        m_pend  = 0;
    endtask

    task automatic host_write(input int a, input int d);
        we = 1'b1; waddr = a[3:0]; wdata = d[7:0];
        step();
        we = 1'b0;
        if (a < NB) m_bank[1 - m_front][a] = d & 8'hFF;
        $display("write back[%0d]=0x%02h", a, d & 8'hFF);
    endtask

    task automatic swap_idle();
        swap = 1'b1;
        step();
        swap = 1'b0;
        m_front = 1 - m_front;
        chk("swapped_pulse", swapped, 1);
        step();
        chk("swapped_drop", swapped, 0);
        $display("swap in idle, front=%0d", m_front);
    endtask

    // mode 0: READY=1, 1: READY pattern 1,0,0,1, 2: random READY.
    task automatic run_frame(input int mode, input int swap_at, input bit with_swap, input int abort_at);
        int  exp_q[$];
        int  k, cyc, g, a, d;
        bit  rdy, vflag, exp_sw, sw_done;
        chk("idle_valid", valid, 0);
        start = 1'b1; swap = with_swap;
        step();
        start = 1'b0; swap = 1'b0;
        exp_sw = with_swap | m_pend;
        if (exp_sw) begin m_front = 1 - m_front; m_pend = 0; end
        chk("swapped_at_start", swapped, exp_sw);
        chk("busy_at_start", busy, 1);
        for (int i = 0; i < NB; i++) exp_q.push_back(m_bank[m_front][i]);
        k = 0; cyc = 0; sw_done = 0;
        while (k < NB && cyc < 400) begin
            chk("valid", valid, 1);
            chk("data", data, exp_q[k]);
            chk("last", last, (k == NB - 1) ? 1 : 0);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_last", last, 0);
                chk("rst_data", data, 0);
                model_clear();
                step();
                rst_n = 1'b1;
                $display("frame aborted by reset at byte %0d", k);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            ready = rdy;
            if (k == swap_at && !sw_done) begin
                swap = 1'b1; m_pend = 1; sw_done = 1;
            end
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, NB - 1); d = $urandom_range(0, 255);
                we = 1'b1; waddr = a[3:0]; wdata = d[7:0];
                m_bank[1 - m_front][a] = d;
            end
            step();
            we = 1'b0; swap = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        chk("stream_done_in_budget", k, NB);
        exp_sw = m_pend;
        if (m_pend) begin m_front = 1 - m_front; m_pend = 0; end
        chk("swapped_at_end", swapped, exp_sw);
        chk("valid_after_last", valid, 0);
        chk("last_after_last", last, 0);
        g = 0; vflag = 0;
        while (busy && g < GAP + 50) begin
            g++;
            vflag |= valid;
            start = (g == GAP / 2);
            ready = $urandom_range(0, 1) == 1;
            step();
            start = 1'b0;
        end
        ready = 1'b0;
        chk("gap_len", g, GAP);
        chk("gap_valid", vflag, 0);
        step();
        chk("idle_after_gap_busy", busy, 0);
        chk("idle_after_gap_valid", valid, 0);
        $display("frame mode=%0d swap_at=%0d with_swap=%0d gap=%0d front=%0d", mode, swap_at, with_swap, g, m_front);
    endtask

    initial begin
        int b_cnt;
        model_clear();
        rst_n = 1'b0;
        #1;
        chk("reset_data", data, 0);
        chk("reset_valid", valid, 0);
        chk("reset_last", last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_swapped", swapped, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NB; i++) host_write(i, 8'h10 + i);
        swap_idle();
        run_frame(0, -1, 0, -1);
        run_frame(1, -1, 0, -1);

        for (int i = 0; i < NB; i++) host_write(i, 8'hAA);
        run_frame(2, 5, 0, -1);
        run_frame(0, -1, 0, -1);

        for (int i = 0; i < NB; i++) host_write(i, $urandom_range(0, 255));
        run_frame(2, -1, 1, -1);

        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < 4; j++) host_write($urandom_range(0, NB - 1), $urandom_range(0, 255));
            run_frame(2, ($urandom_range(0, 1) == 1) ? $urandom_range(0, NB - 1) : -1,
                      $urandom_range(0, 1) == 1, -1);
        end

        for (int i = 0; i < NB; i++) host_write(i, 8'h55);
        swap_idle();
        run_frame(0, -1, 0, 7);
        step();
        run_frame(0, -1, 0, -1);

        // Smaller instance: indices 12..15 are out of range and must be ignored.
        for (int a = 0; a < 16; a++) begin
            b_we = 1'b1; b_waddr = a[3:0]; b_wdata = 8'(8'h40 + a);
            step();
        end
        b_we = 1'b0;
        for (int a = 12; a < 16; a++) begin
            b_we = 1'b1; b_waddr = a[3:0]; b_wdata = 8'hEE;
            step();
        end
        b_we = 1'b0; b_swap = 1'b1; b_start = 1'b1; b_ready = 1'b1;
        step();
        b_swap = 1'b0; b_start = 1'b0;
        chk("b_swapped", b_swapped, 1);
        for (int i = 0; i < NB_B; i++) begin
            chk("b_valid", b_valid, 1);
            chk("b_data", b_data, 8'h40 + i);
            chk("b_last", b_last, (i == NB_B - 1) ? 1 : 0);
            step();
        end
        b_ready = 1'b0;
        b_cnt = 0;
        while (b_busy && b_cnt < 20) begin
            b_cnt++;
            step();
        end
        chk("b_gap_len", b_cnt, GAP_B);
        chk("b_valid_idle", b_valid, 0);
        $display("small instance frame done, gap=%0d", b_cnt);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
